// File: rtl/hdmi_channel_overlay.sv
// Per-pixel colour generator for the HDMI path: per-channel background plus a scaled
// decimal glyph of the active channel, highlighted for a few frames after each change.
module hdmi_channel_overlay #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned CH_W         = 2,
   parameter int unsigned SCALE        = 2,
   parameter int unsigned ORIGIN_X     = 0,
   parameter int unsigned ORIGIN_Y     = 0,
   parameter int unsigned FLASH_FRAMES = 30
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     px_x,
   input  logic [11:0]     px_y,
   input  logic            data_en,
   input  logic [CH_W-1:0] channel_select,
   input  logic            show_overlay,
   output logic [7:0]      r,
   output logic [7:0]      g,
   output logic [7:0]      b,
   output logic            out_de
);

   localparam int unsigned COORD_W = 12;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned RGB_W   = 24;

   localparam logic [RGB_W-1:0] COL_BLACK = 24'h000000;
   localparam logic [RGB_W-1:0] COL_WHITE = 24'hFFFFFF;
   localparam logic [RGB_W-1:0] COL_GREY  = 24'h404040;
   localparam logic [RGB_W-1:0] COL_PAL0  = 24'hC86E3C;
   localparam logic [RGB_W-1:0] COL_PAL1  = 24'h78C864;
   localparam logic [RGB_W-1:0] COL_PAL2  = 24'h32B4C8;
   localparam logic [RGB_W-1:0] COL_PAL3  = 24'h646464;

   typedef enum logic {NORMAL, FLASH} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   flash_cnt, flash_cnt_nx;
   logic [CH_W-1:0]    active_ch, active_ch_nx;

   logic               fs_c;
   logic [CH_W-1:0]    ch_eff_c;
   logic [COORD_W-1:0] dx_c, dy_c, gx_full_c, gy_full_c;
   logic               in_cell_c;

   logic [CH_W-1:0]    s1_ch;
   logic [2:0]         s1_gx;
   logic [3:0]         s1_gy;
   logic               s1_in_cell, s1_de, s1_show;
   state_t             s1_state;

   logic [31:0]        ch_ext_c;
   logic               valid_c;
   logic [7:0]         row_bits_c;
   logic               glyph_px_c;
   logic [RGB_W-1:0]   bg_c, col_c;

   // Digit bitmaps, rows 1..9 packed MSB-first; rows 0, 10, 11 are always blank.
   function automatic logic [7:0] glyph_row(input logic [3:0] digit, input logic [3:0] row);
      logic [71:0] bm;
      case (digit)
         4'd0:    bm = 72'h3C_66_66_6E_76_66_66_66_3C;
         4'd1:    bm = 72'h08_18_78_18_18_18_18_18_7E;
         4'd2:    bm = 72'h3C_66_06_06_0C_18_30_60_7E;
         4'd3:    bm = 72'h3C_66_06_06_1C_06_06_66_3C;
         4'd4:    bm = 72'h0C_1C_3C_6C_4C_7E_0C_0C_0C;
         4'd5:    bm = 72'h7E_60_60_7C_06_06_06_66_3C;
         4'd6:    bm = 72'h1C_30_60_60_7C_66_66_66_3C;
         4'd7:    bm = 72'h7E_06_06_0C_0C_18_18_18_18;
         4'd8:    bm = 72'h3C_66_66_66_3C_66_66_66_3C;
         4'd9:    bm = 72'h3C_66_66_66_3E_06_06_0C_38;
         default: bm = '0;
      endcase
      case (row)
         4'd1:    glyph_row = bm[71:64];
         4'd2:    glyph_row = bm[63:56];
         4'd3:    glyph_row = bm[55:48];
         4'd4:    glyph_row = bm[47:40];
         4'd5:    glyph_row = bm[39:32];
         4'd6:    glyph_row = bm[31:24];
         4'd7:    glyph_row = bm[23:16];
         4'd8:    glyph_row = bm[15:8];
         4'd9:    glyph_row = bm[7:0];
         default: glyph_row = 8'h00;
      endcase
   endfunction

   // Frame start detection, effective channel and glyph-cell geometry
   always_comb begin
      fs_c      = data_en && (px_x == '0) && (px_y == '0);
      ch_eff_c  = fs_c ? channel_select : active_ch;
      dx_c      = px_x - COORD_W'(ORIGIN_X);
      dy_c      = px_y - COORD_W'(ORIGIN_Y);
      gx_full_c = dx_c >> SCALE;
      gy_full_c = dy_c >> SCALE;
      in_cell_c = (px_x >= COORD_W'(ORIGIN_X)) && (px_y >= COORD_W'(ORIGIN_Y)) &&
                  (gx_full_c < 12'd8) && (gy_full_c < 12'd12);
   end

   // Highlight FSM and channel latch, both advanced only at frame start
   always_comb begin
      state_nx     = state;
      flash_cnt_nx = flash_cnt;
      active_ch_nx = active_ch;
      if (fs_c) begin
         active_ch_nx = channel_select;
         if (channel_select != active_ch) begin
            state_nx     = FLASH;
            flash_cnt_nx = CNT_W'(FLASH_FRAMES);
         end else begin
            case (state)
               FLASH: begin
                  if (flash_cnt == CNT_W'(1)) begin
                     state_nx     = NORMAL;
                     flash_cnt_nx = '0;
                  end else begin
                     flash_cnt_nx = flash_cnt - CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= NORMAL;
         flash_cnt <= '0;
         active_ch <= '0;
      end else begin
         state     <= state_nx;
         flash_cnt <= flash_cnt_nx;
         active_ch <= active_ch_nx;
      end
   end

   // Stage 1: the pixel carries the pre-update highlight state with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_ch      <= '0;
         s1_gx      <= '0;
         s1_gy      <= '0;
         s1_in_cell <= 1'b0;
         s1_de      <= 1'b0;
         s1_show    <= 1'b0;
         s1_state   <= NORMAL;
      end else begin
         s1_ch      <= ch_eff_c;
         s1_gx      <= 3'(gx_full_c);
         s1_gy      <= 4'(gy_full_c);
         s1_in_cell <= in_cell_c;
         s1_de      <= data_en;
         s1_show    <= show_overlay;
         s1_state   <= state;
      end
   end

   // Stage 2 combinational: palette, ROM lookup and colour priority mux
   always_comb begin
      ch_ext_c   = 32'(s1_ch);
      valid_c    = ch_ext_c < 32'(NUM_CHANNELS);
      row_bits_c = glyph_row(4'(ch_ext_c), s1_gy);
      glyph_px_c = row_bits_c[3'd7 - s1_gx];
      case (ch_ext_c[1:0])
         2'd0:    bg_c = COL_PAL0;
         2'd1:    bg_c = COL_PAL1;
         2'd2:    bg_c = COL_PAL2;
         default: bg_c = COL_PAL3;
      endcase
      if (!valid_c) bg_c = COL_GREY;

      col_c = bg_c;
      if (!s1_de) begin
         col_c = COL_BLACK;
      end else if (s1_in_cell && s1_show && valid_c) begin
         if (s1_state == NORMAL) col_c = glyph_px_c ? COL_WHITE : bg_c;
         else                    col_c = glyph_px_c ? COL_BLACK : COL_WHITE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r      <= '0;
         g      <= '0;
         b      <= '0;
         out_de <= 1'b0;
      end else begin
         r      <= col_c[23:16];
         g      <= col_c[15:8];
         b      <= col_c[7:0];
         out_de <= s1_de;
      end
   end

endmodule

// File: tb/tb_hdmi_channel_overlay.sv
// Scoreboard bench for hdmi_channel_overlay: directed pixels push expected colours,
// a negedge monitor pops them when out_de is high and checks colour and latency.
module tb_hdmi_channel_overlay;

   localparam logic [23:0] BG0   = 24'hC86E3C;
   localparam logic [23:0] BG1   = 24'h78C864;
   localparam logic [23:0] BG2   = 24'h32B4C8;
   localparam logic [23:0] GREY  = 24'h404040;
   localparam logic [23:0] WHITE = 24'hFFFFFF;
   localparam logic [23:0] BLACK = 24'h000000;

   typedef struct {
      logic [23:0] rgb;
      int          stamp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] px_x = '0;
   logic [11:0] px_y = '0;
   logic        data_en = 1'b1;
   logic [1:0]  channel_select = '0;
   logic        show_overlay = 1'b1;
   logic [7:0]  r, g, b;
   logic        out_de;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   hdmi_channel_overlay #(
      .NUM_CHANNELS(3), .CH_W(2), .SCALE(2),
      .ORIGIN_X(0), .ORIGIN_Y(0), .FLASH_FRAMES(3)
   ) dut (
      .clk(clk), .rst(rst), .px_x(px_x), .px_y(px_y), .data_en(data_en),
      .channel_select(channel_select), .show_overlay(show_overlay),
      .r(r), .g(g), .b(b), .out_de(out_de)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: zeros under reset or blanking, otherwise pop and compare
   always @(negedge clk) begin
      if (!rst) begin
         n_chk++;
         if (out_de !== 1'b0 || {r, g, b} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_out: got de=%b rgb=%06h, want de=0 rgb=000000", out_de, {r, g, b});
         end
      end else if (out_de === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: got rgb=%06h at cyc %0d, want no output", {r, g, b}, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if ({r, g, b} !== mon_e.rgb || cyc != mon_e.stamp + 2) begin
               n_fail++;
               $display("FAIL %s: got rgb=%06h at cyc %0d, want rgb=%06h at cyc %0d",
                        mon_e.name, {r, g, b}, cyc, mon_e.rgb, mon_e.stamp + 2);
            end
         end
      end else begin
         n_chk++;
         if (out_de !== 1'b0 || {r, g, b} !== 24'h0) begin
            n_fail++;
            $display("FAIL blank_out: got de=%b rgb=%06h, want de=0 rgb=000000", out_de, {r, g, b});
         end
      end
   end

   task automatic px(input int x, input int y, input logic [1:0] ch, input logic ov,
                     input logic [23:0] e, input string nm);
      exp_t it;
      @(negedge clk);
      px_x           = 12'(x);
      px_y           = 12'(y);
      data_en        = 1'b1;
      channel_select = ch;
      show_overlay   = ov;
      it.rgb   = e;
      it.stamp = cyc;
      it.name  = nm;
      exp_q.push_back(it);
   endtask

   task automatic blank();
      @(negedge clk);
      data_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with data_en high
      repeat (5) @(negedge clk);
      rst     = 1'b1;
      data_en = 1'b0;

      // Frame A: channel 0; a mid-frame request for 2 is ignored
      px(0, 0, 2'd0, 1'b1, BG0, "fsA_bg0");
      px(100, 300, 2'd2, 1'b1, BG0, "hold_ch");
      px(101, 300, 2'd2, 1'b1, BG0, "hold_ch2");
      px(2, 2, 2'd2, 1'b1, BG0, "hold_cell");

      // Frames B..E: switch to 2, highlight lasts three frames
      px(0, 0, 2'd2, 1'b1, BG2, "fsB_pre");
      px(0, 8, 2'd2, 1'b1, WHITE, "flashN");
      px(40, 40, 2'd2, 1'b1, BG2, "bgB");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsC");
      px(0, 8, 2'd2, 1'b1, WHITE, "flashN1");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsD");
      px(0, 8, 2'd2, 1'b1, WHITE, "flashN2");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsE_pre");
      px(0, 8, 2'd2, 1'b1, BG2, "normalN3");

      // Frames F..K: change to 1, then a second change restarts the count
      px(0, 0, 2'd1, 1'b1, BG1, "fsF");
      px(16, 4, 2'd1, 1'b1, BLACK, "inv_glyph");
      px(12, 4, 2'd1, 1'b1, WHITE, "inv_bg");
      px(0, 0, 2'd1, 1'b1, WHITE, "fsG");
      px(40, 40, 2'd2, 1'b1, BG1, "midchg_ignored");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsH");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsI");
      px(0, 8, 2'd2, 1'b1, WHITE, "restart1");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsJ");
      px(0, 8, 2'd2, 1'b1, WHITE, "restart2");
      px(0, 0, 2'd2, 1'b1, WHITE, "fsK");
      px(0, 8, 2'd2, 1'b1, BG2, "restart_end");

      // Frames L..P: channel 1 settles, then glyph bitmap checks
      px(0, 0, 2'd1, 1'b1, BG1, "fsL");
      px(0, 0, 2'd1, 1'b1, WHITE, "fsM");
      px(0, 0, 2'd1, 1'b1, WHITE, "fsO");
      px(0, 0, 2'd1, 1'b1, WHITE, "fsP");
      px(16, 4, 2'd1, 1'b1, WHITE, "glyph_on");
      px(12, 4, 2'd1, 1'b1, BG1, "glyph_off");
      for (int y = 36; y < 40; y++)
         for (int x = 4; x < 28; x++)
            px(x, y, 2'd1, 1'b1, WHITE, "row9");
      px(0, 36, 2'd1, 1'b1, BG1, "row9_col0");
      px(28, 36, 2'd1, 1'b1, BG1, "row9_col7");
      px(32, 4, 2'd1, 1'b1, BG1, "outside_x");

      // Frame Q: out-of-range channel
      px(0, 0, 2'd3, 1'b1, GREY, "fsQ");
      px(16, 4, 2'd3, 1'b1, GREY, "oor_glyph");
      px(0, 8, 2'd3, 1'b1, GREY, "oor_cell");
      px(200, 100, 2'd3, 1'b1, GREY, "oor_bg");

      // Frame T: fs sees FLASH entered by Q; overlay disable
      px(0, 0, 2'd1, 1'b1, WHITE, "fsT_flash");
      px(0, 8, 2'd1, 1'b0, BG1, "ov_off");
      px(16, 4, 2'd1, 1'b0, BG1, "ov_off_glyph");
      px(0, 8, 2'd1, 1'b1, WHITE, "ov_on");

      // Blanking 1,0,1
      px(50, 50, 2'd1, 1'b1, BG1, "de1");
      blank();
      px(52, 50, 2'd1, 1'b1, BG1, "de3");

      // Asynchronous reset while in FLASH
      px(0, 8, 2'd1, 1'b1, WHITE, "pre_rst");
      px(60, 60, 2'd1, 1'b1, BG1, "pre_rst2");
      @(posedge clk);
      #1;
      n_chk++;
      if (out_de !== 1'b1 || {r, g, b} !== WHITE) begin
         n_fail++;
         $display("FAIL pre_rst_live: got de=%b rgb=%06h, want de=1 rgb=ffffff", out_de, {r, g, b});
      end
      rst = 1'b0;
      exp_q.delete();
      #1;
      n_chk++;
      if (out_de !== 1'b0 || {r, g, b} !== 24'h0) begin
         n_fail++;
         $display("FAIL rst_immediate: got de=%b rgb=%06h, want de=0 rgb=000000", out_de, {r, g, b});
      end
      data_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // After reset: active channel 0, state NORMAL
      px(0, 0, 2'd0, 1'b1, BG0, "post_rst_fs");
      px(0, 8, 2'd0, 1'b1, BG0, "post_rst_normal");

      repeat (4) blank();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending outputs, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hdmi_channel_overlay.md
# hdmi_channel_overlay

Parametrised pixel-colour generator for the HDMI output path. It takes the pixel coordinate and data-enable from the HDMI timing generator and fills the active area with a per-channel background colour. It draws the selected channel number as a scaled 8x12 decimal glyph at a configurable origin. When the channel changes, the glyph is highlighted for a fixed number of frames. Channel changes are applied only at frame boundaries, so the output never tears, and the output is pipelined with a matching delayed data-enable.

## Interface
- NUM_CHANNELS, 4: number of valid channels; legal range 1..10.
- CH_W, 2: width of channel_select; 2^CH_W >= NUM_CHANNELS.
- SCALE, 2: log2 of the glyph pixel size; legal range 0..4.
- ORIGIN_X, 0: glyph cell left edge, in pixels.
- ORIGIN_Y, 0: glyph cell top edge, in pixels.
- FLASH_FRAMES, 30: number of frames the highlight lasts; legal range 1..255.

Ports:
- clk  in  1  pixel clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- px_x  in  12  pixel column.
- px_y  in  12  pixel row.
- data_en  in  1  active-video qualifier.
- channel_select  in  CH_W  requested channel.
- show_overlay  in  1  glyph enable; when low, only the background is drawn.
- r  out  8  red.
- g  out  8  green.
- b  out  8  blue.
- out_de  out  1  data_en delayed to align with r/g/b.

## Operation
- **Frame start (fs):** data_en=1 && px_x==0 && px_y==0 at the input.
- **Channel sampling:** active_ch is loaded from channel_select only on fs. Between fs events, changes on channel_select are ignored. The fs pixel itself uses channel_select directly: ch_eff = fs ? channel_select : active_ch.
- **Background palette:** indexed by ch_eff mod 4.
  - 0 → (200,110,60)
  - 1 → (120,200,100)
  - 2 → (50,180,200)
  - 3 → (100,100,100)
  - ch_eff >= NUM_CHANNELS → (64,64,64), no glyph drawn.
- **Glyph cell geometry:**
  - gx = (px_x − ORIGIN_X) >> SCALE; gy = (px_y − ORIGIN_Y) >> SCALE, using 12-bit unsigned arithmetic.
  - A pixel is in the cell when px_x >= ORIGIN_X, px_y >= ORIGIN_Y, gx < 8 and gy < 12. The >= checks prevent wrap-around false hits.
- **Glyph ROM:**
  - 10 digits × 12 rows × 8 bits; bit (7−gx) is the pixel at column gx.
  - Rows 0, 10 and 11 and columns 0 and 7 are blank for every digit.
  - Digit 1 is fixed: row1=0x08, row2=0x18, row3=0x78, rows4–8=0x18, row9=0x7E.
  - Digits 0 and 2–9 are legible, pairwise distinct and confined to rows 1–9, columns 1–6.
- **Glyph drawn:** the decimal value of ch_eff.
- **Highlight FSM** (states NORMAL, FLASH; 8-bit flash_cnt):
  - On fs with channel_select != active_ch, from either state: flash_cnt ← FLASH_FRAMES and state ← FLASH. A change during FLASH reloads the counter.
  - On fs in FLASH with no change: if flash_cnt==1, state ← NORMAL and flash_cnt ← 0; otherwise flash_cnt ← flash_cnt − 1.
  - FSM updates are independent of show_overlay and of whether the channel is valid.
- **Colour selection** (first matching rule wins):
  1. data_en=0 → (0,0,0).
  2. In cell, show_overlay=1, channel valid, state NORMAL: glyph pixel → (255,255,255); non-glyph pixel → background.
  3. Same conditions, state FLASH: glyph pixel → (0,0,0); non-glyph pixel → (255,255,255). The whole 8x12 cell is drawn inverted.
  4. Otherwise → background.
- The state used for a pixel is the state in effect when that pixel enters stage 1. The fs pixel sees the pre-update state.

## Timing
- **Pipeline stage 1:** registers ch_eff, gx, gy, in_cell, data_en and state.
- **Pipeline stage 2:** registers the ROM lookup and the colour mux into r/g/b/out_de.
- **Latency:** exactly 2 clk cycles from input to r/g/b/out_de; throughput is 1 pixel per cycle.
- **Alignment:** out_de is data_en delayed by 2 cycles.
- **Reset (rst=0, asynchronous):**
  - r/g/b = 0 and out_de = 0.
  - active_ch = 0, flash_cnt = 0, state = NORMAL.
  - Pipeline registers are cleared.
  - Release is synchronous to clk. The first valid output appears 2 cycles after the first data_en following release.
- **Reset mid-FLASH:** the highlight is aborted, and the next fs compares channel_select against active_ch=0.

## Test plan
- **Reset:** hold rst=0 for 5 cycles while data_en=1 → r/g/b/out_de=0 throughout. After release, with channel_select=0 and a fs, the first output is at +2 cycles and the background is (200,110,60).
- **Glyph bitmap:** SCALE=2, ORIGIN=(0,0), channel 1 stable for 2 frames.
  - Pixel (16,4) → (255,255,255), since gx=4, gy=1.
  - Pixel (12,4) → (120,200,100).
  - Pixels (4..27, 36..39) are white, matching row 9 = 0x7E.
- **Frame-boundary sampling:**
  - channel_select changes 0→2 at pixel (100,300) → remaining pixels of that frame keep (200,110,60).
  - From the next fs → (50,180,200) and FSM enters FLASH.
- **Highlight duration:** FLASH_FRAMES=3; change the channel, then hold it stable.
  - The inverted cell appears in frames N, N+1 and N+2.
  - Frame N+3 shows a white glyph on the background, with state NORMAL.
  - Repeat with a second change during frame N+1 → the count restarts from 3.
- **Out-of-range channel:** NUM_CHANNELS=3, channel_select=3 → whole active area (64,64,64), no glyph. The FSM still enters FLASH. Setting show_overlay=0 on a valid channel → background only.
- **Blanking and latency:** data_en toggling 1,0,1 → out_de toggles 1,0,1 two cycles later, with (0,0,0) on the blank cycle. Asserting rst mid-FLASH → outputs go to 0 immediately and state returns to NORMAL after release.
